// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants for the main-memory bus controller: state encodings,
// default geometry and latencies, and the wait-counter load helper.
package mem_bus_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 1024;
    localparam int DEF_RD_LATENCY = 2;
    localparam int DEF_WR_LATENCY = 1;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;
    localparam logic [1:0] ST_HOLD   = 2'b11;

    // The counter reaches zero in the last wait cycle, so it is loaded with latency-1.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_mem_array.sv
// Single-port word RAM with synchronous write and asynchronous read;
// the parent registers the read result.
module mem_bus_ctrl_mem_array
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      index,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Main-memory bus controller: services one held arbiter request at a time
// against on-chip RAM with programmable read/write wait states.
//
// state  | meaning
// IDLE   | waiting for req_valid; captures the request
// ACCESS | counting wait states; memory access on the terminal count
// RESP   | data_valid pulse cycle
// HOLD   | request serviced, waiting for the arbiter to drop req_valid
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_LATENCY = DEF_WR_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_flush,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wrt_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  data_valid,
    output logic                  bus_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [DATA_WIDTH-1:0] req_data;

    logic [IDX_W-1:0]      index;
    logic                  addr_err;
    logic                  commit;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign index    = req_addr[IDX_W+1:2];
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_WIDTH-1:IDX_W+2] != '0);
    assign commit   = (state == ST_ACCESS) && (cnt == '0);
    // A flush on the commit edge does not block the write.
    assign mem_we   = commit && req_we && !addr_err;

    mem_bus_ctrl_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .index (index),
        .wdata (req_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_data   <= '0;
            rd_data    <= '0;
            data_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (commit && !req_we && !addr_err) begin
                rd_data <= mem_rdata;
            end
            if (system_flush) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                data_valid <= 1'b0;
                bus_err    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            req_addr <= addr;
                            req_we   <= we;
                            req_data <= wrt_data;
                            cnt      <= we ? lat_load(WR_LATENCY) : lat_load(RD_LATENCY);
                            state    <= ST_ACCESS;
                        end
                    end
                    ST_ACCESS: begin
                        if (cnt == '0) begin
                            data_valid <= 1'b1;
                            bus_err    <= addr_err;
                            state      <= ST_RESP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_RESP: begin
                        data_valid <= 1'b0;
                        bus_err    <= 1'b0;
                        state      <= req_valid ? ST_HOLD : ST_IDLE;
                    end
                    ST_HOLD: begin
                        if (!req_valid) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: an arbiter-style driver pushes the
// expected completion (cycle, rd_data, bus_err) and a monitor checks each pulse.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int RD    = 2;
    localparam int WR    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          system_flush;
    logic          req_valid;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wrt_data;
    logic [DW-1:0] rd_data;
    logic          data_valid;
    logic          bus_err;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd = 32'h0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    mem_bus_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .RD_LATENCY (RD),
        .WR_LATENCY (WR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .system_flush (system_flush),
        .req_valid    (req_valid),
        .addr         (addr),
        .we           (we),
        .wrt_data     (wrt_data),
        .rd_data      (rd_data),
        .data_valid   (data_valid),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] word_addr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = word_addr();
        if (r == 0)      a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = a | (32'h1000 << $urandom_range(0, 19));
        return a;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_dv at cycle %0d: got data_valid=1, expected 0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dv_cycle", 32'(cyc), 32'(e.cyc));
                    check("rd_data", rd_data, e.rd);
                    check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                end
            end else if (bus_err) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_bus_err at cycle %0d: got bus_err=1 without data_valid, expected 0", cyc);
            end
        end
    end

    // Request is live in cycle t; wait for its pulse, optionally hold, then drop.
    task automatic push_and_wait(input logic [31:0] a, input logic w, input logic [31:0] d,
                                 input int t, input int hold);
        exp_t e;
        bit   err;
        bit   seen;
        err = model_err(a);
        if (w) begin
            if (!err) model_mem[a / 4] = d;
        end else if (!err) begin
            model_rd = model_mem[a / 4];
        end
        e.cyc = t + (w ? WR : RD) + 1;
        e.rd  = model_rd;
        e.err = err;
        sb.push_back(e);
        @(posedge clk); #1;
        addr     = $urandom;
        we       = 1'($urandom);
        wrt_data = $urandom;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (data_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL dv_timeout at cycle %0d: got no data_valid, expected one for addr %h", cyc, a);
            sb.delete();
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d, input int hold);
        @(posedge clk); #1;
        req_valid = 1'b1;
        addr      = a;
        we        = w;
        wrt_data  = d;
        push_and_wait(a, w, d, cyc, hold);
    endtask

    // Flush k cycles after the request is raised; keep=1 leaves req_valid high.
    task automatic flush_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input int k, input bit keep);
        int lat;
        lat = w ? WR : RD;
        @(posedge clk); #1;
        req_valid = 1'b1;
        addr      = a;
        we        = w;
        wrt_data  = d;
        repeat (k) @(posedge clk);
        #1;
        system_flush = 1'b1;
        if (!keep) req_valid = 1'b0;
        if (w && !model_err(a) && k >= lat) model_mem[a / 4] = d;
        @(posedge clk); #1;
        system_flush = 1'b0;
        @(negedge clk);
        check("flush_quiet_dv", {31'd0, data_valid}, 32'd0);
        check("flush_quiet_err", {31'd0, bus_err}, 32'd0);
        if (keep) push_and_wait(a, w, d, cyc, 0);
        else      repeat (3) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        system_flush = 1'b0;
        req_valid    = 1'b0;
        addr         = '0;
        we           = 1'b0;
        wrt_data     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_dv", {31'd0, data_valid}, 32'd0);
        check("reset_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 32; i++)
            do_req(32'(i) << 2, 1'b1, (i == 4) ? 32'hDEADBEEF : $urandom, 0);

        do_req(32'h10, 1'b0, 32'h0, 0);
        do_req(32'h20, 1'b1, 32'h12345678, 0);
        do_req(32'h20, 1'b0, 32'h0, 0);
        do_req(32'h14, 1'b0, 32'h0, 10);

        do_req(32'h0000_1000, 1'b1, 32'hCAFEF00D, 0);
        do_req(32'h0000_0002, 1'b1, 32'hBAD0BAD0, 0);
        do_req(32'h0000_0000, 1'b0, 32'h0, 0);
        do_req(32'h8000_0000, 1'b0, 32'h0, 0);

        flush_req(32'h30, 1'b1, 32'hA5A5A5A5, 1, 1'b0);
        do_req(32'h30, 1'b0, 32'h0, 0);
        flush_req(32'h34, 1'b1, 32'h5A5A5A5A, WR, 1'b0);
        do_req(32'h34, 1'b0, 32'h0, 0);
        flush_req(32'h38, 1'b0, 32'h0, 1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) do_req(word_addr(), 1'b0, 32'h0, 0);
            else            do_req(word_addr(), 1'b1, $urandom, 0);
        end

        for (int i = 0; i < 40; i++)
            do_req(rand_addr(), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));

        @(posedge clk); #1;
        req_valid = 1'b1;
        addr      = 32'h8;
        we        = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_rd_data", rd_data, 32'h0);
        check("midreset_dv", {31'd0, data_valid}, 32'd0);
        model_rd = 32'h0;
        do_req(32'h8, 1'b0, 32'h0, 0);

        repeat (5) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
